// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared glyphs, converter state encoding and helpers for the scan driver
package ssd_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_DASH  = 7'b0000001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Decimal digits needed to hold any data_w-bit value (log10(2) ~ 0.302).
  function automatic int bcd_digits(input int data_w);
    return (data_w * 302) / 1000 + 1;
  endfunction

  function automatic logic [6:0] seg_glyph(input logic [3:0] n);
    case (n)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/ssd_scan_driver_if.sv
// rtl/ssd_scan_driver_if.sv - value/control inputs and display pin outputs of the scan driver
interface ssd_scan_driver_if #(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_W     = 16
);
  logic [DATA_W-1:0]     value_in;
  logic                  load;
  logic [NUM_DIGITS-1:0] dp_in;
  logic                  blank_lz;
  logic                  blink_en;
  logic                  busy;
  logic                  overflow;
  logic [NUM_DIGITS-1:0] anode;
  logic [6:0]            seg;
  logic                  dp;

  modport master (
    output value_in, load, dp_in, blank_lz, blink_en,
    input  busy, overflow, anode, seg, dp
  );

  modport slave (
    input  value_in, load, dp_in, blank_lz, blink_en,
    output busy, overflow, anode, seg, dp
  );
endinterface

// File: rtl/ssd_bin2bcd.sv
// rtl/ssd_bin2bcd.sv - iterative shift-add-3 binary to BCD converter, one input bit per clock
module ssd_bin2bcd
  import ssd_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int BCD_D  = bcd_digits(DATA_W)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic [DATA_W-1:0]    i_value,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [BCD_D*4-1:0]   o_bcd
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [1:0]         r_state;
  logic [DATA_W-1:0]  r_bin;
  logic [BCD_D*4-1:0] r_bcd;
  logic [BCD_D*4-1:0] w_adj;
  logic [CNT_W-1:0]   r_cnt;

  always_comb begin
    w_adj = r_bcd;
    for (int k = 0; k < BCD_D; k++) begin
      if (r_bcd[k*4 +: 4] >= 4'd5)
        w_adj[k*4 +: 4] = r_bcd[k*4 +: 4] + 4'd3;
    end
  end

  // Loads arriving outside IDLE are dropped, not queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_load) begin
            r_bin   <= i_value;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_bcd <= {w_adj[BCD_D*4-2:0], r_bin[DATA_W-1]};
          r_bin <= r_bin << 1;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(DATA_W - 1))
            r_state <= ST_DONE;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy = (r_state != ST_IDLE);
  assign o_done = (r_state == ST_DONE);
  assign o_bcd  = r_bcd;

endmodule

// File: rtl/ssd_scan_driver.sv
// rtl/ssd_scan_driver.sv - multiplexed seven-segment driver: BCD conversion, scan, blanking, blink
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DATA_W       = 16,
  parameter int REFRESH_BITS = 19,
  parameter int BLINK_BITS   = 25,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  ssd_scan_driver_if.slave  bus
);

  localparam int BCD_D = bcd_digits(DATA_W);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic POL = (ACTIVE_LOW != 0);

  logic                    w_busy;
  logic                    w_done;
  logic [BCD_D*4-1:0]      w_bcd;
  logic                    w_ovf_next;
  logic [3:0]              r_digits [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   r_dp_cap;
  logic [NUM_DIGITS-1:0]   r_dp;
  logic                    r_ovf;
  logic [REFRESH_BITS-1:0] r_refresh;
  logic [BLINK_BITS-1:0]   r_blink;
  logic [IDX_W-1:0]        r_idx;
  logic [NUM_DIGITS-1:0]   w_blank;
  logic [NUM_DIGITS-1:0]   w_anode;
  logic [6:0]              w_seg;
  logic                    w_dp;
  logic [NUM_DIGITS-1:0]   r_anode;
  logic [6:0]              r_seg;
  logic                    r_dp_out;

  ssd_bin2bcd #(.DATA_W(DATA_W), .BCD_D(BCD_D)) u_conv (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (bus.load),
    .i_value (bus.value_in),
    .o_busy  (w_busy),
    .o_done  (w_done),
    .o_bcd   (w_bcd)
  );

  generate
    if (BCD_D > NUM_DIGITS) begin : g_ovf
      assign w_ovf_next = |w_bcd[BCD_D*4-1:NUM_DIGITS*4];
    end else begin : g_no_ovf
      assign w_ovf_next = 1'b0;
    end
  endgenerate

  // Decimal points are captured with the value but shown only once the digits commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dp_cap <= '0;
      r_dp     <= '0;
      r_ovf    <= 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) r_digits[k] <= 4'd0;
    end else begin
      if (bus.load && !w_busy) r_dp_cap <= bus.dp_in;
      if (w_done) begin
        r_dp  <= r_dp_cap;
        r_ovf <= w_ovf_next;
        for (int k = 0; k < NUM_DIGITS; k++) r_digits[k] <= w_bcd[k*4 +: 4];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_refresh <= '0;
      r_blink   <= '0;
      r_idx     <= '0;
    end else begin
      r_refresh <= r_refresh + 1'b1;
      r_blink   <= r_blink + 1'b1;
      if (&r_refresh)
        r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
    end
  end

  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    w_blank  = '0;
    // Scan from the top digit down; digit 0 is never marked blank.
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      zero_run   = zero_run && (r_digits[k] == 4'd0);
      w_blank[k] = zero_run;
    end
    if (r_ovf) begin
      w_seg = SEG_DASH;
      w_dp  = 1'b0;
    end else if (bus.blank_lz && w_blank[r_idx]) begin
      w_seg = SEG_BLANK;
      w_dp  = r_dp[r_idx];
    end else begin
      w_seg = seg_glyph(r_digits[r_idx]);
      w_dp  = r_dp[r_idx];
    end
    w_anode = '0;
    if (!(bus.blink_en && r_blink[BLINK_BITS-1]))
      w_anode[r_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_anode  <= {NUM_DIGITS{POL}};
      r_seg    <= {7{POL}};
      r_dp_out <= POL;
    end else begin
      r_anode  <= w_anode ^ {NUM_DIGITS{POL}};
      r_seg    <= w_seg ^ {7{POL}};
      r_dp_out <= w_dp ^ POL;
    end
  end

  assign bus.busy     = w_busy;
  assign bus.overflow = r_ovf;
  assign bus.anode    = r_anode;
  assign bus.seg      = r_seg;
  assign bus.dp       = r_dp_out;

endmodule

// File: doc/ssd_scan_driver.md
Name: ssd_scan_driver

Overview:
Parametrised multiplexed seven-segment display driver for N-digit common-anode/cathode displays on the board.
- Converts a binary value to BCD with an iterative shift-add-3 engine, one bit per clock. The previous design used combinational divide/modulo.
- Latches the converted digits into a display register.
- Time-multiplexes the digits with a refresh counter.
- Adds leading-zero blanking, per-digit decimal points, blinking and an overflow indication.
- Sits between game/score logic and the board pins.

Parameters:
- NUM_DIGITS, 4: number of physical digits driven.
- DATA_W, 16: width of the binary input value.
- REFRESH_BITS, 19: each digit is lit for 2^REFRESH_BITS clocks.
- BLINK_BITS, 25: blink phase is counter bit BLINK_BITS-1. Must be > REFRESH_BITS.
- ACTIVE_LOW, 1: 1 means anode/seg/dp are active-low; 0 means active-high.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- value_in  in  DATA_W  binary value to display; sampled on load.
- load  in  1  single-cycle request to convert value_in; honoured only when busy=0.
- dp_in  in  NUM_DIGITS  decimal-point enables; bit i belongs to digit i. Sampled on load.
- blank_lz  in  1  1 enables leading-zero blanking; used live.
- blink_en  in  1  1 enables whole-display blinking; used live.
- busy  out  1  conversion in progress.
- overflow  out  1  last committed value is >= 10^NUM_DIGITS.
- anode  out  NUM_DIGITS  digit enables; bit i is digit i, where digit 0 is least significant.
- seg  out  7  segments {a,b,c,d,e,f,g}, bit 6 = a.
- dp  out  1  decimal point of the currently scanned digit.

Behaviour:
- Reset (async assert, sync release):
  - Converter goes to IDLE; busy=0; overflow=0.
  - Display register holds all zeros; dp register is cleared.
  - Refresh, blink and digit-index counters are 0.
  - anode, seg and dp are all inactive (all ones when ACTIVE_LOW=1).
- Reset asserted mid-conversion aborts the conversion. The old display contents are lost.
- Converter FSM:
  - IDLE: on load, capture value_in and dp_in, clear the BCD shift register, set busy=1, go to SHIFT. A load while busy=1 is ignored, with no queueing.
  - SHIFT: runs exactly DATA_W cycles. Each cycle, add 3 to every BCD nibble >= 5, then shift left one bit, bringing in the binary MSB.
  - DONE: one cycle. Commit the low NUM_DIGITS nibbles to the display register. Set overflow if any higher BCD nibble is nonzero. busy=0 on exit; go to IDLE.
  - The internal BCD register holds BCD_D = (DATA_W*302)/1000+1 digits, and must satisfy BCD_D >= NUM_DIGITS.
  - Latency: load at cycle 0 means the display register and overflow are updated at the edge ending cycle DATA_W+1. busy is high for cycles 1..DATA_W+1.
- Scan:
  - The refresh counter is REFRESH_BITS wide and free-running.
  - On its wrap, the digit index increments modulo NUM_DIGITS, in order 0,1,...,NUM_DIGITS-1,0.
  - anode, seg and dp are registered: they change one clock after an index change.
  - Exactly one anode is active per scan slot, except while blanked.
- Digit content for index i, in priority order:
  - overflow=1: seg shows segment g only (dash) on every digit; dp off.
  - blank_lz=1, i>0, and every digit j>=i is zero: digit fully blank (seg all inactive). The anode still scans. Digit 0 is never blanked, so value 0 shows "0".
  - Otherwise: decimal glyph. Nibble values >9 cannot occur; if forced, show the dash.
- Decimal glyphs, active-high, bit 6 = a:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
- Polarity: when ACTIVE_LOW=1, anode, seg and dp are all inverted.
- Blink: blink_en=1 and blink-counter bit BLINK_BITS-1 = 1 forces all anodes inactive. The counters keep running.
- Display updates are atomic: the register changes only in DONE, so a conversion never shows partial digits.

Decomposition:
- Shared package ssd_pkg holds:
  - segment glyph constants SEG_0..SEG_9, SEG_DASH and SEG_BLANK (active-high);
  - converter state encoding (IDLE/SHIFT/DONE).
- Sub-module ssd_bin2bcd holds the iterative converter: load, value, busy, done, bcd. The top level contains the scan counters, blanking logic and output registers.

Test Plan:
Bench setup for all scenarios: REFRESH_BITS=2, BLINK_BITS=6, ACTIVE_LOW=1.
1. Release reset, no load -> anode=1111/seg=1111111 during the reset cycle. Then digit 0 shows "0" (seg=0000001); digits 1..3 show "0" with blank_lz=0 and are blank with blank_lz=1.
2. load value_in=1234 -> busy high for 17 cycles. Then scan slots 0..3 show 4,3,2,1 with anode 1110,1101,1011,0111; overflow=0.
3. load 12345 with NUM_DIGITS=4 -> overflow=1; all digits show seg=1111110 (dash).
4. load 7 with blank_lz=1 and dp_in=0010 -> only digit 0 shows "7", digits 1..3 blank. dp is active only in slot 1, showing a lone point.
5. load while busy: second load of 9999 at cycle 5 after loading 42 -> ignored; display shows 42.
6. blink_en=1 -> anodes all 1111 for 32 of every 64 clocks. Assert rst_n=0 mid-conversion -> busy drops at once; display returns to "0".
